ex_mem_commit: RTL
==================

// Module: ex_mem_commit
// PURPOSE
//  Consumer side of the execute-stage ALU outputs: captures EX_AluData/EX_BranchPC/EX_BranchFlag/EX_LdStFlag
//  into the EX/MEM pipeline register. Runs the data-cache request/ack handshake for loads and stores, and
//  load-extends the returned word. Issues a one-cycle branch redirect to fetch and drives the MEM->EX forwarding bus.
// PARAMETERS
//  DATA_WIDTH     32  scalar data / cache word width
//  ADDR_WIDTH     32  address / PC width
//  LD_TYPE_WIDTH  3   load type code width (0 none,1 LB,2 LH,3 LW,4 LBU,5 LHU)
//  ST_TYPE_WIDTH  2   store type code width (0 none,1 SB,2 SH,3 SW)
// PORTS
//  clk             in   1   core clock
//  rst_n           in   1   asynchronous active-low reset
//  EX_Valid        in   1   EX stage holds a valid instruction this cycle
//  EX_AluData      in   DW  ALU result / effective address
//  EX_BranchPC     in   AW  branch target
//  EX_BranchFlag   in   1   branch/jump taken
//  EX_LdStFlag     in   1   instruction is a load or store
//  IDEX_LdType     in   LTW load type;  IDEX_StType in STW store type
//  IDEX_Rd         in   5   destination register;  IDEX_RegWrite in 1 writes rd
//  forward_rs2     in   DW  store data (already forwarded)
//  EX_Ready        out  1   EX/MEM register accepts this cycle (EX may advance)
//  Dcache_Req      out  1   cache request valid;  Dcache_Ack in 1 request complete
//  Dcache_Addr     out  AW  word-aligned address;  Dcache_WrEn out 1;  Dcache_ByteEn out 4
//  Dcache_WrData   out  DW  lane-aligned store data;  Dcache_RdData in DW returned word
//  EXMEM_Valid     out  1   WB-bound instruction valid (one cycle per instruction)
//  EXMEM_Rd        out  5;  EXMEM_RegWrite out 1;  EXMEM_WbData out DW
//  Redirect_Valid  out  1   one-cycle fetch redirect;  Redirect_PC out AW
//  Fwd_Valid       out  1;  Fwd_Rd out 5;  Fwd_Data out DW  forwarding to EX (valid only when data final)
// BEHAVIOUR
//  Reset: every output 0, FSM=IDLE, all pipeline registers 0; effective immediately on rst_n low.
//  FSM IDLE / ACCESS / COMMIT:
//   IDLE: EX_Ready=1. On EX_Valid, latch all EX/IDEX inputs.
//     Non-LdSt -> COMMIT. LdSt -> ACCESS.
//   ACCESS: Dcache_Req=1, with address/data/ByteEn stable; EX_Ready=0.
//     Stay until Dcache_Ack; on ack latch extended load data, then -> COMMIT.
//     Ack in the same cycle Req rises is legal.
//   COMMIT: EXMEM_Valid=1 for exactly one cycle. EX_Ready=1; a new EX_Valid is latched the same cycle
//     (back-to-back: next state ACCESS/COMMIT per new instr, else IDLE).
//  Latency: ALU op 1 cycle EX->EXMEM_Valid; load/store 1 + cache cycles + 1.
//  Lanes: off=addr[1:0]. SB ByteEn=1<<off, data replicated x4. SH ByteEn=off[1]?1100:0011, data replicated x2.
//   SW ByteEn=1111, off ignored. Dcache_Addr={addr[AW-1:2],2'b00}.
//  Loads: select byte/half by off (half uses off[1]); LB/LH sign-extend, LBU/LHU zero-extend, LW as-is.
//   Misalignment is trapped upstream and not checked here.
//  Stores: EXMEM_RegWrite forced 0. Dcache_WrEn=1 iff StType!=0.
//  Redirect: Redirect_Valid pulses 1 cycle, the cycle after a valid instr with EX_BranchFlag=1 is latched.
//   Redirect_PC=latched EX_BranchPC. Never asserted for a stalled duplicate.
//  Forwarding: Fwd_Valid=1 when the EX/MEM register holds a RegWrite instr, Rd!=0, and its data is final
//   (non-load latched, or load after ack). During a load in ACCESS, Fwd_Valid=0 (EX sees the hazard).
//  Rd==0: EXMEM_RegWrite forced 0.
//  EX_Valid while EX_Ready=0: ignored; EX must hold its inputs.
//  Reset mid-ACCESS: request drops immediately; the cache must discard the in-flight request.
// STRUCTURE
//  Shared package/defines: LD_*/ST_* type codes, FSM state encoding, widths (existing DATA/ADDR/LD/ST macros).
//  One sub-module: ld_st_align (combinational store lane/ByteEn generation and load select/extend).
//  Top keeps the FSM and registers.
// TESTING
//  ADD result 0x0000_0005, Rd=3 -> next cycle EXMEM_Valid=1, WbData=5, Fwd_Valid=1, Fwd_Rd=3; EX_Ready stays 1.
//  LB addr 0x1003, RdData 0x80xx_xxxx, Ack after 3 cycles -> Req high 3 cycles, WbData=0xFFFF_FF80.
//   Same with LBU -> 0x0000_0080.
//  SH addr 0x2002, rs2=0x1234_ABCD -> ByteEn=1100, WrData=0xABCD_ABCD, WrEn=1; EXMEM_RegWrite=0.
//  Taken branch BranchPC=0x0000_0400 -> Redirect_Valid single pulse, Redirect_PC=0x400.
//   A second branch back-to-back gives a second pulse.
//  Load then dependent ADD presented while ACCESS -> EX_Ready=0, Fwd_Valid=0 until ack.
//   The ADD is accepted in the COMMIT cycle.
//  rst_n low during ACCESS -> Req, EXMEM_Valid, Redirect_Valid 0 at once; after release, FSM=IDLE with no commit.

Source files
------------

// File: rtl/ex_mem_commit_pkg.sv
// ex_mem_commit_pkg
//  Shared definitions for the EX/MEM commit slice:
//   - default data/address/type widths
//   - load (LD_*) and store (ST_*) type codes
//   - EX/MEM control FSM state encoding
//   - helper for halfword byte-enable generation
package ex_mem_commit_pkg;

   localparam int DEF_DATA_WIDTH    = 32;
   localparam int DEF_ADDR_WIDTH    = 32;
   localparam int DEF_LD_TYPE_WIDTH = 3;
   localparam int DEF_ST_TYPE_WIDTH = 2;
   localparam int REG_ADDR_WIDTH    = 5;

   localparam logic [DEF_LD_TYPE_WIDTH-1:0] LD_NONE = 3'd0;
   localparam logic [DEF_LD_TYPE_WIDTH-1:0] LD_LB   = 3'd1;
   localparam logic [DEF_LD_TYPE_WIDTH-1:0] LD_LH   = 3'd2;
   localparam logic [DEF_LD_TYPE_WIDTH-1:0] LD_LW   = 3'd3;
   localparam logic [DEF_LD_TYPE_WIDTH-1:0] LD_LBU  = 3'd4;
   localparam logic [DEF_LD_TYPE_WIDTH-1:0] LD_LHU  = 3'd5;

   localparam logic [DEF_ST_TYPE_WIDTH-1:0] ST_NONE = 2'd0;
   localparam logic [DEF_ST_TYPE_WIDTH-1:0] ST_SB   = 2'd1;
   localparam logic [DEF_ST_TYPE_WIDTH-1:0] ST_SH   = 2'd2;
   localparam logic [DEF_ST_TYPE_WIDTH-1:0] ST_SW   = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_COMMIT = 2'd2
   } state_t;

   // Halfword lanes: upper half when address bit 1 is set.
   function automatic logic [3:0] sh_byte_en(input logic hi);
      return hi ? 4'b1100 : 4'b0011;
   endfunction

endpackage

// File: rtl/ex_mem_commit_ld_st_align.sv
// ex_mem_commit_ld_st_align
//  Combinational lane logic for a 32-bit data cache word.
//  Ports:
//   addr_off  in  2   byte offset within the word
//   st_type   in  STW store type (ST_*)
//   st_data   in  32  store data, right-aligned
//   ld_type   in  LTW load type (LD_*)
//   rd_data   in  32  word returned by the cache
//   byte_en   out 4   byte enables for the store (all ones when not a store)
//   wr_data   out 32  store data replicated into every candidate lane
//   ld_data   out 32  selected and sign/zero-extended load result
module ex_mem_commit_ld_st_align
   import ex_mem_commit_pkg::*;
(
   input  logic [1:0]                   addr_off,
   input  logic [DEF_ST_TYPE_WIDTH-1:0] st_type,
   input  logic [31:0]                  st_data,
   input  logic [DEF_LD_TYPE_WIDTH-1:0] ld_type,
   input  logic [31:0]                  rd_data,
   output logic [3:0]                   byte_en,
   output logic [31:0]                  wr_data,
   output logic [31:0]                  ld_data
);

   logic [3:0]  sb_en;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         assign sb_en[gi] = (addr_off == 2'(gi));
      end
   endgenerate

   assign ld_byte = rd_data[{addr_off, 3'b000} +: 8];
   assign ld_half = addr_off[1] ? rd_data[31:16] : rd_data[15:0];

   // Replicating the store data means the cache picks the right lane
   // purely from byte_en; no shifter on the write path.
   always_comb begin
      byte_en = 4'b1111;
      wr_data = st_data;
      case (st_type)
         ST_SB: begin
            byte_en = sb_en;
            wr_data = {4{st_data[7:0]}};
         end
         ST_SH: begin
            byte_en = sh_byte_en(addr_off[1]);
            wr_data = {2{st_data[15:0]}};
         end
         default: ;
      endcase
   end

   always_comb begin
      ld_data = rd_data;
      case (ld_type)
         LD_LB:   ld_data = {{24{ld_byte[7]}}, ld_byte};
         LD_LH:   ld_data = {{16{ld_half[15]}}, ld_half};
         LD_LBU:  ld_data = {24'h0, ld_byte};
         LD_LHU:  ld_data = {16'h0, ld_half};
         default: ;
      endcase
   end

endmodule

// File: rtl/ex_mem_commit.sv
// ex_mem_commit
//  EX/MEM pipeline register and data-cache handshake.
//  Captures the EX result, runs a Req/Ack cache access for loads/stores,
//  commits one EXMEM_Valid pulse per instruction, pulses a fetch redirect
//  for taken branches and drives the MEM->EX forwarding bus.
//  Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   EX_Valid/EX_AluData/EX_BranchPC/EX_BranchFlag/EX_LdStFlag   EX inputs
//   IDEX_LdType/IDEX_StType/IDEX_Rd/IDEX_RegWrite, forward_rs2  decode info
//   EX_Ready                       EX may advance this cycle
//   Dcache_Req/Ack/Addr/WrEn/ByteEn/WrData/RdData   cache interface
//   EXMEM_Valid/Rd/RegWrite/WbData                  writeback bundle
//   Redirect_Valid/PC                               fetch redirect
//   Fwd_Valid/Rd/Data                               forwarding to EX
module ex_mem_commit
   import ex_mem_commit_pkg::*;
#(
   parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH,
   parameter int LD_TYPE_WIDTH = DEF_LD_TYPE_WIDTH,
   parameter int ST_TYPE_WIDTH = DEF_ST_TYPE_WIDTH
)(
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      EX_Valid,
   input  logic [DATA_WIDTH-1:0]     EX_AluData,
   input  logic [ADDR_WIDTH-1:0]     EX_BranchPC,
   input  logic                      EX_BranchFlag,
   input  logic                      EX_LdStFlag,
   input  logic [LD_TYPE_WIDTH-1:0]  IDEX_LdType,
   input  logic [ST_TYPE_WIDTH-1:0]  IDEX_StType,
   input  logic [4:0]                IDEX_Rd,
   input  logic                      IDEX_RegWrite,
   input  logic [DATA_WIDTH-1:0]     forward_rs2,
   output logic                      EX_Ready,
   output logic                      Dcache_Req,
   input  logic                      Dcache_Ack,
   output logic [ADDR_WIDTH-1:0]     Dcache_Addr,
   output logic                      Dcache_WrEn,
   output logic [3:0]                Dcache_ByteEn,
   output logic [DATA_WIDTH-1:0]     Dcache_WrData,
   input  logic [DATA_WIDTH-1:0]     Dcache_RdData,
   output logic                      EXMEM_Valid,
   output logic [4:0]                EXMEM_Rd,
   output logic                      EXMEM_RegWrite,
   output logic [DATA_WIDTH-1:0]     EXMEM_WbData,
   output logic                      Redirect_Valid,
   output logic [ADDR_WIDTH-1:0]     Redirect_PC,
   output logic                      Fwd_Valid,
   output logic [4:0]                Fwd_Rd,
   output logic [DATA_WIDTH-1:0]     Fwd_Data
);

   state_t                     state_reg, state_next;
   logic [DATA_WIDTH-1:0]      addr_reg;
   logic [DATA_WIDTH-1:0]      st_data_reg;
   logic [DATA_WIDTH-1:0]      wb_data_reg;
   logic [ADDR_WIDTH-1:0]      branch_pc_reg;
   logic                       redirect_valid_reg;
   logic [LD_TYPE_WIDTH-1:0]   ld_type_reg;
   logic [ST_TYPE_WIDTH-1:0]   st_type_reg;
   logic [4:0]                 rd_reg;
   logic                       reg_write_reg;

   logic                       ready;
   logic                       accept;
   logic                       in_access;
   logic                       in_commit;
   logic [3:0]                 lane_en;
   logic [DATA_WIDTH-1:0]      lane_wr_data;
   logic [DATA_WIDTH-1:0]      ld_data;

   ex_mem_commit_ld_st_align u_align (
      .addr_off (addr_reg[1:0]),
      .st_type  (st_type_reg),
      .st_data  (st_data_reg),
      .ld_type  (ld_type_reg),
      .rd_data  (Dcache_RdData),
      .byte_en  (lane_en),
      .wr_data  (lane_wr_data),
      .ld_data  (ld_data)
   );

   // COMMIT also accepts, so single-cycle ops stream at one per clock.
   always_comb begin
      state_next = state_reg;
      ready      = 1'b0;
      case (state_reg)
         ST_IDLE, ST_COMMIT: begin
            ready = 1'b1;
            if (EX_Valid)
               state_next = EX_LdStFlag ? ST_ACCESS : ST_COMMIT;
            else
               state_next = ST_IDLE;
         end
         ST_ACCESS: begin
            if (Dcache_Ack)
               state_next = ST_COMMIT;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   assign accept    = ready && EX_Valid;
   assign in_access = (state_reg == ST_ACCESS);
   assign in_commit = (state_reg == ST_COMMIT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg          <= ST_IDLE;
         addr_reg           <= '0;
         st_data_reg        <= '0;
         wb_data_reg        <= '0;
         branch_pc_reg      <= '0;
         redirect_valid_reg <= 1'b0;
         ld_type_reg        <= '0;
         st_type_reg        <= '0;
         rd_reg             <= '0;
         reg_write_reg      <= 1'b0;
      end else begin
         state_reg          <= state_next;
         redirect_valid_reg <= accept && EX_BranchFlag;
         if (accept) begin
            addr_reg      <= EX_AluData;
            wb_data_reg   <= EX_AluData;
            st_data_reg   <= forward_rs2;
            branch_pc_reg <= EX_BranchPC;
            ld_type_reg   <= EX_LdStFlag ? IDEX_LdType : LD_NONE;
            st_type_reg   <= EX_LdStFlag ? IDEX_StType : ST_NONE;
            rd_reg        <= IDEX_Rd;
            // Stores and x0 never write the register file.
            reg_write_reg <= IDEX_RegWrite && (IDEX_Rd != 5'd0) &&
                             !(EX_LdStFlag && (IDEX_StType != ST_NONE));
         end else if (in_access && Dcache_Ack && (ld_type_reg != LD_NONE)) begin
            wb_data_reg <= ld_data;
         end
      end
   end

   // Ready is gated by rst_n so every output reads 0 while reset is held.
   assign EX_Ready       = ready && rst_n;

   assign Dcache_Req     = in_access;
   assign Dcache_Addr    = {addr_reg[ADDR_WIDTH-1:2], 2'b00};
   assign Dcache_WrEn    = in_access && (st_type_reg != ST_NONE);
   assign Dcache_ByteEn  = in_access ? lane_en : 4'b0000;
   assign Dcache_WrData  = lane_wr_data;

   assign EXMEM_Valid    = in_commit;
   assign EXMEM_Rd       = rd_reg;
   assign EXMEM_RegWrite = reg_write_reg;
   assign EXMEM_WbData   = wb_data_reg;

   assign Redirect_Valid = redirect_valid_reg;
   assign Redirect_PC    = branch_pc_reg;

   // Data is final only in COMMIT: a load still in ACCESS has no value yet.
   assign Fwd_Valid      = in_commit && reg_write_reg;
   assign Fwd_Rd         = rd_reg;
   assign Fwd_Data       = wb_data_reg;

endmodule
